multicycle_mem_unit: RTL
========================

// Module: multicycle_mem_unit
// PURPOSE
//   Responder side of the multicycle controller's memory control bus.
//   Consumes IorD/MemRead/MemWrite/IRWrite and owns the unified word-addressed RAM, the
//   instruction register (IR) and the memory data register (MDR).
//   Returns the opcode field to the controller and exposes a mem_ready handshake for wait-state
//   controllers. Sits between the control FSM and the datapath register file/ALU.
// PARAMETERS
//   ADDR_WIDTH  8  word-address bits; RAM depth = 2**ADDR_WIDTH 32-bit words
//   LATENCY     0  wait cycles per access; 0 = single-cycle (current controller), 1..15 = stalled
// PORTS
//   clk         in   1   clock, rising edge
//   reset       in   1   asynchronous, active-high
//   IorD        in   1   address select: 0 = pc, 1 = alu_out
//   MemRead     in   1   read request
//   MemWrite    in   1   write request
//   IRWrite     in   1   load IR from read data
//   pc          in   32  program counter (byte address)
//   alu_out     in   32  ALUOut register (byte address)
//   write_data  in   32  store data (register B)
//   instr       out  32  IR contents
//   opcode      out  6   instr[31:26], to control FSM
//   mdr         out  32  MDR contents
//   mem_ready   out  1   access complete this cycle
//   misaligned  out  1   sticky: request seen with addr[1:0] != 0
// BEHAVIOUR
//   - Address: addr = IorD ? alu_out : pc.
//     - Word index = addr[ADDR_WIDTH+1:2]; upper bits ignored, so out-of-range addresses wrap.
//     - addr[1:0] are ignored for the access.
//   - Reset (async): instr=0, mdr=0, mem_ready=0, misaligned=0, FSM->IDLE, wait counter=0.
//     - RAM contents are not reset.
//     - A reset mid-access aborts it; an uncommitted write is dropped.
//   - LATENCY=0 (no FSM):
//     - Read data is combinational mem[idx].
//     - mem_ready = MemRead|MemWrite, combinational.
//     - Write commits at the edge on which MemWrite=1.
//     - IR loads rdata at the edge when IRWrite=1; MDR loads rdata at every edge when MemRead=1.
//   - LATENCY>0 FSM: IDLE, RD_WAIT, WR_WAIT, DONE.
//     - IDLE: MemWrite=1 -> capture idx+write_data, go WR_WAIT. Else MemRead=1 -> capture idx,
//       go RD_WAIT. Counter loads LATENCY-1.
//     - RD_WAIT/WR_WAIT: counter decrements each cycle; at 0 -> DONE.
//       - WR_WAIT->DONE edge commits the write.
//       - RD_WAIT->DONE edge registers mem[idx] into rdata.
//     - DONE: mem_ready=1 for exactly one cycle (registered).
//       - MDR <= rdata on a read; IR <= rdata if IRWrite=1 in this cycle. -> IDLE.
//     - Total: request in cycle N -> mem_ready in cycle N+LATENCY+1.
//     - Request inputs are ignored outside IDLE; address/data are captured at acceptance, so
//       in-flight changes have no effect.
//   - MemRead and MemWrite both high: write wins, no read performed, MDR unchanged.
//   - Read-after-write to same word: a read accepted after the write's commit edge returns the new data.
//   - IRWrite with no read completing: IR holds.
//   - misaligned: set on the accepting edge of any request with addr[1:0]!=0; clears only on reset.
//   - opcode = instr[31:26], always combinational from IR.
// TESTING
//   1 LATENCY=0: preload mem[1]=0x8C220004; pc=4, IorD=0, MemRead=1, IRWrite=1, one edge
//     -> instr=0x8C220004, opcode=0x23, mem_ready=1 during that cycle.
//   2 LATENCY=0: alu_out=0x10, write_data=0xDEADBEEF, IorD=1, MemWrite=1, one edge;
//     then MemRead=1 -> mdr=0xDEADBEEF.
//   3 LATENCY=2: MemRead at cycle 0, pc=8 (mem[2]=0x12345678)
//     -> mem_ready=1 only in cycle 3, mdr=0x12345678 after that edge; pc changed in cycle 1
//     has no effect.
//   4 LATENCY=2: MemRead=MemWrite=1, alu_out=0x20, write_data=0xA5A5A5A5
//     -> mem[8]=0xA5A5A5A5; MDR unchanged; mem_ready pulses in cycle 3.
//   5 Reset asserted in WR_WAIT (LATENCY=3) -> outputs 0 immediately; mem[idx] keeps its old
//     value; next request starts from IDLE.
//   6 alu_out=0x1002 with ADDR_WIDTH=8 -> word 0x00 accessed (wrap) and misaligned=1 until reset.

Source files
------------

// File: rtl/multicycle_mem_unit.sv
// Memory responder for the multicycle controller: unified word RAM, IR and MDR.
// LATENCY=0 gives a combinational single-cycle access; LATENCY>0 adds a wait-state FSM.
module multicycle_mem_unit #(
    parameter int ADDR_WIDTH = 8,
    parameter int LATENCY    = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        IorD,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        IRWrite,
    input  logic [31:0] pc,
    input  logic [31:0] alu_out,
    input  logic [31:0] write_data,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [31:0] mdr,
    output logic        mem_ready,
    output logic        misaligned
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [31:0]           r_mem [DEPTH];
    logic [31:0]           r_ir;
    logic [31:0]           r_mdr;
    logic                  r_mis;
    logic [31:0]           w_addr;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic                  w_req;
    logic                  w_unaligned;
    logic                  w_unused_hi;

    assign w_addr      = IorD ? alu_out : pc;
    assign w_idx       = w_addr[ADDR_WIDTH+1:2];
    assign w_req       = MemRead | MemWrite;
    assign w_unaligned = (w_addr[1:0] != 2'b00);
    // Upper address bits are dropped on purpose so oversize addresses wrap.
    assign w_unused_hi = ^w_addr[31:ADDR_WIDTH+2];

    assign instr      = r_ir;
    assign opcode     = r_ir[31:26];
    assign mdr        = r_mdr;
    assign misaligned = r_mis;

    generate
        if (LATENCY == 0) begin : g_single
            logic [31:0] w_rdata;
            logic        w_rd;

            assign w_rdata   = r_mem[w_idx];
            assign w_rd      = MemRead & ~MemWrite;
            assign mem_ready = w_req;

            always_ff @(posedge clk) begin
                if (!reset && MemWrite)
                    r_mem[w_idx] <= write_data;
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_ir  <= '0;
                    r_mdr <= '0;
                    r_mis <= 1'b0;
                end else begin
                    if (w_rd)
                        r_mdr <= w_rdata;
                    if (w_rd && IRWrite)
                        r_ir <= w_rdata;
                    if (w_req && w_unaligned)
                        r_mis <= 1'b1;
                end
            end
        end else begin : g_wait
            typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, DONE} state_t;
            localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

            state_t                r_state;
            state_t                w_next;
            logic [3:0]            r_cnt;
            logic [ADDR_WIDTH-1:0] r_idx;
            logic [31:0]           r_wdata;
            logic [31:0]           r_rdata;
            logic                  r_rd;

            always_ff @(posedge clk or posedge reset) begin
                if (reset)
                    r_state <= IDLE;
                else
                    r_state <= w_next;
            end

            always_comb begin
                w_next = r_state;
                case (r_state)
                    IDLE: begin
                        if (MemWrite)
                            w_next = WR_WAIT;
                        else if (MemRead)
                            w_next = RD_WAIT;
                    end
                    RD_WAIT, WR_WAIT: begin
                        if (r_cnt == 4'd0)
                            w_next = DONE;
                    end
                    DONE:    w_next = IDLE;
                    default: w_next = IDLE;
                endcase
            end

            always_comb begin
                mem_ready = (r_state == DONE);
            end

            // Commit happens on the WR_WAIT->DONE edge; a reset before then leaves RAM untouched.
            always_ff @(posedge clk) begin
                if (r_state == WR_WAIT && r_cnt == 4'd0)
                    r_mem[r_idx] <= r_wdata;
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_cnt   <= '0;
                    r_idx   <= '0;
                    r_wdata <= '0;
                    r_rdata <= '0;
                    r_rd    <= 1'b0;
                    r_ir    <= '0;
                    r_mdr   <= '0;
                    r_mis   <= 1'b0;
                end else begin
                    case (r_state)
                        IDLE: begin
                            if (w_req) begin
                                r_cnt   <= CNT_INIT;
                                r_idx   <= w_idx;
                                r_wdata <= write_data;
                                r_rd    <= ~MemWrite;
                                if (w_unaligned)
                                    r_mis <= 1'b1;
                            end
                        end
                        RD_WAIT, WR_WAIT: begin
                            if (r_cnt != 4'd0)
                                r_cnt <= r_cnt - 4'd1;
                            else if (r_state == RD_WAIT)
                                r_rdata <= r_mem[r_idx];
                        end
                        DONE: begin
                            if (r_rd) begin
                                r_mdr <= r_rdata;
                                if (IRWrite)
                                    r_ir <= r_rdata;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    endgenerate
endmodule
